if_id_stage: RTL
================

Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS core.
- Owns the PC and drives the combinational instruction-memory address.
- Registers the fetched word and PC+4, and presents decoded fields to the decode stage; id_imm16_o feeds the sign-extension unit directly.
- Supports hazard stall, branch/jump redirect, flush, and two wrap-around performance counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble
CNT_W, 32, width of the performance counters

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
stall_i  in  1  hazard unit: hold PC and IF/ID contents
flush_i  in  1  insert a bubble into IF/ID next edge
redirect_i  in  1  taken branch/jump: load PC from redirect_pc_i
redirect_pc_i  in  32  target address
imem_addr_o  out  32  instruction-memory address (= current PC)
imem_data_i  in  32  instruction word, combinational read of imem_addr_o
id_valid_o  out  1  IF/ID holds a real instruction
id_pc_plus4_o  out  32  registered PC+4 of the held instruction
id_instr_o  out  32  registered instruction word
id_opcode_o  out  6  id_instr_o[31:26]
id_rs_o  out  5  id_instr_o[25:21]
id_rt_o  out  5  id_instr_o[20:16]
id_rd_o  out  5  id_instr_o[15:11]
id_funct_o  out  6  id_instr_o[5:0]
id_imm16_o  out  16  id_instr_o[15:0], to sign-extend unit
fetch_cnt_o  out  CNT_W  count of valid instructions loaded into IF/ID
bubble_cnt_o  out  CNT_W  count of edges on which IF/ID was loaded with a bubble

Behaviour:
- imem_addr_o = pc_q, combinational. Field outputs are pure slices of id_instr_o.
- PC next-state, highest priority first:
  - rst_i -> RESET_PC.
  - redirect_i -> {redirect_pc_i[31:2],2'b00}; low bits are forced to zero.
  - stall_i -> hold.
  - else -> pc_q + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID next-state, highest priority first:
  - rst_i -> bubble.
  - flush_i or redirect_i -> bubble.
  - stall_i -> hold all fields, including valid.
  - else -> load {valid=1, pc_plus4=pc_q+4, instr=imem_data_i}.
- Bubble definition: valid=0, instr=NOP_INSTR, pc_plus4=0.
- Reset values:
  - pc_q = RESET_PC; imem_addr_o = RESET_PC.
  - id_valid_o = 0; id_instr_o = NOP_INSTR; id_pc_plus4_o = 0; all field outputs = slices of NOP_INSTR.
  - fetch_cnt_o = 0; bubble_cnt_o = 0.
- Latency: the instruction at PC p appears on id_instr_o one edge after p is on imem_addr_o, provided no stall, flush or redirect occurs on that edge.
- Simultaneous events:
  - redirect_i + stall_i: redirect wins; PC loads the target and IF/ID takes a bubble.
  - flush_i + stall_i without redirect: PC holds, IF/ID takes a bubble.
  - flush_i + redirect_i: identical to redirect alone.
- Counters, when not in reset:
  - fetch_cnt_o increments on each edge where IF/ID loads a valid instruction.
  - bubble_cnt_o increments on each edge where IF/ID loads a bubble, excluding reset.
  - Neither changes on a stall-hold edge. Both wrap modulo 2^CNT_W.
- Reset asserted mid-stream discards the held instruction; fetch restarts at RESET_PC on the edge after rst_i deasserts.

Test Plan:
- Reset then run 4 cycles, imem returning 32'h2001_0005 at addr 0 and 32'h8C22_0004 at addr 4:
  - Required: imem_addr_o sequence 0,4,8,12.
  - After edge 1: id_instr_o=32'h2001_0005, id_pc_plus4_o=4, id_valid_o=1, id_imm16_o=16'h0005, id_rt_o=1.
  - fetch_cnt_o=4 after the 4th edge.
- Stall for 2 cycles with PC=8: PC stays 8 and IF/ID holds its contents for both cycles; counters unchanged; fetch resumes at 8 then 12.
- redirect_i=1, redirect_pc_i=32'h0000_0043 with stall_i=1 on the same edge:
  - Required: next PC=32'h40, id_valid_o=0, id_instr_o=NOP_INSTR, bubble_cnt_o +1.
  - The next edge loads the word from 0x40.
- flush_i alone with PC=16: PC advances to 20, IF/ID becomes a bubble, the word at 16 is lost, bubble_cnt_o +1.
- Preload pc_q=32'hFFFF_FFFC via redirect, then run one edge: PC wraps to 0 and id_pc_plus4_o=0 with id_valid_o=1.
- Assert rst_i mid-stream with stall_i=1: all outputs return to reset values on that edge and the counters clear.

Source files
------------

// File: rtl/if_id_stage.sv
// if_id_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of the pipelined
//   MIPS core. Owns the PC, drives the combinational instruction-memory
//   address, registers the fetched word together with PC+4, and slices the
//   held word into the fields consumed by decode. Two wrap-around counters
//   track valid fetches and inserted bubbles.
//
// Ports
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   stall_i             hold PC and IF/ID contents
//   flush_i             load a bubble into IF/ID
//   redirect_i          load PC from redirect_pc_i (word aligned), bubble IF/ID
//   redirect_pc_i       redirect target
//   imem_addr_o         instruction-memory address (= PC)
//   imem_data_i         instruction word read combinationally at imem_addr_o
//   id_valid_o          IF/ID holds a real instruction
//   id_pc_plus4_o       PC+4 of the held instruction
//   id_instr_o          held instruction word
//   id_opcode_o .. id_imm16_o   field slices of id_instr_o
//   fetch_cnt_o         valid instructions loaded into IF/ID
//   bubble_cnt_o        bubbles loaded into IF/ID (reset excluded)
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic             id_valid_o,
  output logic [31:0]      id_pc_plus4_o,
  output logic [31:0]      id_instr_o,
  output logic [5:0]       id_opcode_o,
  output logic [4:0]       id_rs_o,
  output logic [4:0]       id_rt_o,
  output logic [4:0]       id_rd_o,
  output logic [5:0]       id_funct_o,
  output logic [15:0]      id_imm16_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [31:0]      pc_plus4_q, pc_plus4_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic [31:0] pc_inc;
  logic        load_bubble;
  logic        load_valid;

  assign pc_inc = pc_q + 32'd4;

  // Redirect dominates stall; flush only affects IF/ID, never the PC.
  assign load_bubble = flush_i | redirect_i;
  assign load_valid  = ~load_bubble & ~stall_i;

  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    pc_plus4_d   = pc_plus4_q;
    instr_d      = instr_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (rst_i) begin
      pc_d         = RESET_PC;
      valid_d      = 1'b0;
      pc_plus4_d   = '0;
      instr_d      = NOP_INSTR;
      fetch_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (redirect_i) begin
        pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      end else if (!stall_i) begin
        pc_d = pc_inc;
      end

      if (load_bubble) begin
        valid_d      = 1'b0;
        pc_plus4_d   = '0;
        instr_d      = NOP_INSTR;
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else if (load_valid) begin
        valid_d     = 1'b1;
        pc_plus4_d  = pc_inc;
        instr_d     = imem_data_i;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q         <= pc_d;
    valid_q      <= valid_d;
    pc_plus4_q   <= pc_plus4_d;
    instr_q      <= instr_d;
    fetch_cnt_q  <= fetch_cnt_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  assign imem_addr_o   = pc_q;
  assign id_valid_o    = valid_q;
  assign id_pc_plus4_o = pc_plus4_q;
  assign id_instr_o    = instr_q;
  assign id_opcode_o   = instr_q[31:26];
  assign id_rs_o       = instr_q[25:21];
  assign id_rt_o       = instr_q[20:16];
  assign id_rd_o       = instr_q[15:11];
  assign id_funct_o    = instr_q[5:0];
  assign id_imm16_o    = instr_q[15:0];
  assign fetch_cnt_o   = fetch_cnt_q;
  assign bubble_cnt_o  = bubble_cnt_q;

endmodule
